// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: one WIDTH/STAGES-bit chunk per stage, fixed STAGES+1 latency.
// Optional saturation of signed overflow results when RCA_PIPE_SAT_EN is defined.
module rca_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             valid_out,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int C = WIDTH / STAGES;

  // Index 0 is the input register; index k holds the state after chunk k-1 has been added.
  logic             v_r  [0:STAGES];
  logic [WIDTH-1:0] a_r  [0:STAGES];
  logic [WIDTH-1:0] b_r  [0:STAGES];
  logic [WIDTH-1:0] s_r  [0:STAGES];
  logic             c_r  [0:STAGES];
  logic             sa_r [0:STAGES];
  logic             sb_r [0:STAGES];

  logic [WIDTH-1:0] b_eff;
  logic [C:0]       chunk_sum [1:STAGES];
  logic [WIDTH-1:0] s_raw;

  assign b_eff = sub ? ~b : b;

  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      chunk_sum[k] = {1'b0, a_r[k-1][(k-1)*C +: C]}
                   + {1'b0, b_r[k-1][(k-1)*C +: C]}
                   + {{C{1'b0}}, c_r[k-1]};
    end
  end

  // NOTE: all pipeline state uses non-blocking assignments so each stage reads the
  // previous stage's value from before this edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= STAGES; k++) begin
        v_r[k]  <= 1'b0;
        a_r[k]  <= '0;
        b_r[k]  <= '0;
        s_r[k]  <= '0;
        c_r[k]  <= 1'b0;
        sa_r[k] <= 1'b0;
        sb_r[k] <= 1'b0;
      end
    end else if (!stall) begin
      v_r[0]  <= valid_in;
      a_r[0]  <= a;
      b_r[0]  <= b_eff;
      s_r[0]  <= '0;
      c_r[0]  <= sub ? 1'b1 : ci;
      sa_r[0] <= a[WIDTH-1];
      sb_r[0] <= b_eff[WIDTH-1];
      for (int k = 1; k <= STAGES; k++) begin
        v_r[k]  <= v_r[k-1];
        a_r[k]  <= a_r[k-1];
        b_r[k]  <= b_r[k-1];
        sa_r[k] <= sa_r[k-1];
        sb_r[k] <= sb_r[k-1];
        s_r[k]  <= s_r[k-1];
        // Later assignment to the same register wins: only chunk k-1 is overwritten.
        s_r[k][(k-1)*C +: C] <= chunk_sum[k][C-1:0];
        c_r[k]  <= chunk_sum[k][C];
      end
    end
  end

  assign s_raw     = s_r[STAGES];
  assign valid_out = v_r[STAGES];
  assign co        = c_r[STAGES];
  assign ovf       = (sa_r[STAGES] == sb_r[STAGES]) && (s_raw[WIDTH-1] != sa_r[STAGES]);

`ifdef RCA_PIPE_SAT_EN
  // Clamp toward the sign of operand A: positive overflow -> 0111..1, negative -> 1000..0.
  assign s = ovf ? {sa_r[STAGES], {(WIDTH-1){~sa_r[STAGES]}}} : s_raw;
`else
  assign s = s_raw;
`endif

endmodule

// File: tb/tb_rca_pipe.sv
// Self-checking bench for rca_pipe: three instances (STAGES=4, 1, 32) driven from shared inputs.
// Expected sums honour RCA_PIPE_SAT_EN when the bench is compiled with that macro.
module tb_rca_pipe;

  localparam int W    = 32;
  localparam int NDUT = 3;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] exp_s;
    logic         exp_co;
    logic         exp_ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset, valid_in, stall, sub, ci;
  logic [W-1:0] a, b;
  logic         vo  [NDUT];
  logic [W-1:0] so  [NDUT];
  logic         coo [NDUT];
  logic         ovo [NDUT];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rca_pipe #(.WIDTH(W), .STAGES(4)) u_s4 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .sub(sub),
    .a(a), .b(b), .ci(ci), .valid_out(vo[0]), .s(so[0]), .co(coo[0]), .ovf(ovo[0]));
  rca_pipe #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .sub(sub),
    .a(a), .b(b), .ci(ci), .valid_out(vo[1]), .s(so[1]), .co(coo[1]), .ovf(ovo[1]));
  rca_pipe #(.WIDTH(W), .STAGES(32)) u_s32 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .sub(sub),
    .a(a), .b(b), .ci(ci), .valid_out(vo[2]), .s(so[2]), .co(coo[2]), .ovf(ovo[2]));

  function automatic int lat_of(input int d);
    case (d)
      0:       return 5;
      1:       return 2;
      default: return 33;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and watch every instance for a single result at its own latency.
  task automatic run_vec(input vec_t v, input string tag);
    int           hit_cnt [NDUT];
    int           hit_t   [NDUT];
    logic [W-1:0] hs      [NDUT];
    logic         hco     [NDUT];
    logic         hov     [NDUT];
    logic [W-1:0] exp_s;
    exp_s = v.exp_s;
`ifdef RCA_PIPE_SAT_EN
    if (v.exp_ovf) exp_s = v.a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    for (int d = 0; d < NDUT; d++) begin
      hit_cnt[d] = 0; hit_t[d] = 0; hs[d] = '0; hco[d] = 1'b0; hov[d] = 1'b0;
    end
    sub = v.sub; a = v.a; b = v.b; ci = v.ci; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    for (int t = 1; t <= 36; t++) begin
      if (t > 1) step();
      for (int d = 0; d < NDUT; d++) begin
        if (vo[d] === 1'b1) begin
          hit_cnt[d]++;
          hit_t[d] = t;
          hs[d]    = so[d];
          hco[d]   = coo[d];
          hov[d]   = ovo[d];
        end
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("%s d%0d count", tag, d), hit_cnt[d], 1);
      check($sformatf("%s d%0d latency", tag, d), hit_t[d], lat_of(d));
      check($sformatf("%s d%0d s", tag, d), hs[d], exp_s);
      check($sformatf("%s d%0d co", tag, d), hco[d], v.exp_co);
      check($sformatf("%s d%0d ovf", tag, d), hov[d], v.exp_ovf);
    end
  endtask

  initial begin
    vec_t         vecs [9];
    vec_t         post;
    int           idx;
    int           nxt    [NDUT];
    int           first  [NDUT];
    int           last   [NDUT];
    int           stray  [NDUT];
    logic [W-1:0] prev_s [NDUT];
    logic         prev_v [NDUT];
    int           exp_first [NDUT];
    int           exp_last  [NDUT];

    //          sub   a             b             ci    exp_s         co    ovf
    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 32'h0000_0004, 1'b0, 1'b0};
    post    = '{1'b0, 32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0};

    // Reset held two cycles with valid_in and stall both high.
    reset = 1'b1; valid_in = 1'b1; stall = 1'b1; sub = 1'b0; ci = 1'b1;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    step();
    step();
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset d%0d valid_out", d), vo[d], 1'b0);
      check($sformatf("reset d%0d s", d), so[d], '0);
      check($sformatf("reset d%0d co", d), coo[d], 1'b0);
      check($sformatf("reset d%0d ovf", d), ovo[d], 1'b0);
      stray[d] = 0;
    end
    reset = 1'b0; stall = 1'b0; valid_in = 1'b0;
    for (int t = 0; t < 10; t++) begin
      step();
      for (int d = 0; d < NDUT; d++) if (vo[d] !== 1'b0) stray[d]++;
    end
    for (int d = 0; d < NDUT; d++) check($sformatf("post-reset idle d%0d", d), stray[d], 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Streaming with a 3-cycle stall; the issuer re-presents an op until an unstalled edge takes it.
    exp_first = '{4, 1, 35};
    exp_last  = '{14, 11, 42};
    for (int d = 0; d < NDUT; d++) begin
      nxt[d] = 0; first[d] = -1; last[d] = -1; prev_s[d] = so[d]; prev_v[d] = vo[d];
    end
    idx = 0; sub = 1'b0; ci = 1'b0;
    for (int t = 0; t < 50; t++) begin
      stall    = (t >= 5 && t <= 7);
      valid_in = (idx < 8);
      a        = 32'(idx);
      b        = 32'(idx * 16);
      step();
      if (!stall && idx < 8) idx++;
      for (int d = 0; d < NDUT; d++) begin
        if (stall) begin
          check($sformatf("stall t%0d d%0d s held", t, d), so[d], prev_s[d]);
          check($sformatf("stall t%0d d%0d valid held", t, d), vo[d], prev_v[d]);
        end else if (vo[d] === 1'b1) begin
          check($sformatf("stream d%0d op%0d s", d, nxt[d]), so[d], 32'(nxt[d] * 17));
          if (first[d] < 0) first[d] = t;
          last[d] = t;
          nxt[d]++;
        end
        prev_s[d] = so[d];
        prev_v[d] = vo[d];
      end
    end
    stall = 1'b0; valid_in = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("stream d%0d delivered", d), nxt[d], 8);
      check($sformatf("stream d%0d first", d), first[d], exp_first[d]);
      check($sformatf("stream d%0d last", d), last[d], exp_last[d]);
    end

    // Reset pulse after three issues: nothing issued before it may ever emerge.
    for (int i = 0; i < 3; i++) begin
      a = 32'(i + 1); b = 32'h100; valid_in = 1'b1;
      step();
    end
    reset = 1'b1; a = 32'h4; valid_in = 1'b1;
    step();
    reset = 1'b0; valid_in = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("midreset d%0d valid_out", d), vo[d], 1'b0);
      check($sformatf("midreset d%0d s", d), so[d], '0);
      stray[d] = 0;
    end
    for (int t = 0; t < 40; t++) begin
      step();
      for (int d = 0; d < NDUT; d++) if (vo[d] !== 1'b0) stray[d]++;
    end
    for (int d = 0; d < NDUT; d++) check($sformatf("midreset d%0d stray", d), stray[d], 0);
    run_vec(post, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rca_pipe.md
Name: rca_pipe

Overview:
- Parametrised pipelined ripple-carry adder/subtractor; next generation of the team's registered 32-bit RCA wrapper.
- Operand width and carry-pipeline depth are configurable. Adds add/subtract mode, valid tagging, a global stall and carry/overflow flags.
- Sits in the datapath as a registered arithmetic unit. It accepts one operation per clock and delivers results in order at fixed latency.

Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, number of carry-pipeline stages; each stage adds one WIDTH/STAGES-bit chunk. Range 1..WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  operands/mode on this cycle form an operation.
- stall  input  1  freeze entire pipeline (all registers hold).
- sub  input  1  0: a+b+ci; 1: a+~b+1 (ci ignored).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in (add mode only).
- valid_out  output  1  s/co/ovf hold a completed operation.
- s  output  WIDTH  sum/difference.
- co  output  1  carry-out of MSB; in sub mode 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clocking: single clock clk. Reset is synchronous and active-high on port reset; sampled on the rising edge only.
- Reset: every pipeline register cleared on the edge where reset=1.
  - valid_out=0, s=0, co=0, ovf=0 from the following cycle.
  - Reset overrides stall.
  - Reset mid-operation discards all in-flight operations; none emerge afterwards.
- Input register (stage 0), on each edge with stall=0:
  - Captures valid_in, a, effective b (b or ~b), effective carry (ci or 1).
  - Captures sign bits a[W-1] and effective-b[W-1] for the overflow check.
- Chunk stages k=1..STAGES, C=WIDTH/STAGES:
  - Stage k adds chunk k-1 of the operands plus the carry registered by stage k-1, and registers the chunk sum and chunk carry-out.
  - Lower chunk results, upper unconsumed operand chunks and valid are carried forward in skew/deskew registers, so one operation always occupies one pipeline slot.
- Latency: exactly STAGES+1 rising edges from the accepting edge to valid_out=1 with that operation's result.
  - STAGES=1 gives 2 cycles, matching the existing registered RCA.
- Throughput: one operation per cycle; results exit in issue order.
- Bubbles: valid_in=0 cycles travel through as valid_out=0 slots.
  - s/co/ovf in those slots carry whatever the datapath computed. Consumers must qualify them with valid_out.
- Stall: while stall=1, no register updates.
  - Outputs hold their values; inputs are ignored.
  - No operation is lost or duplicated across a stall of any length.
  - On release, the pipeline resumes from the frozen state.
- Arithmetic:
  - {co,s} = a + b_eff + c_eff modulo 2^(WIDTH+1).
  - ovf = (a[W-1]==b_eff[W-1]) && (s[W-1]!=a[W-1]).
- Boundaries:
  - A full-length carry (e.g. all-ones + 1) must ripple correctly across every stage boundary.
  - STAGES=WIDTH (1-bit chunks) must work.

Optional Feature:
- Macro: RCA_PIPE_SAT_EN.
- Defined: when ovf=1 for a result, s is replaced with the signed limit.
  - Positive overflow (a[W-1]=0) gives 0111..1; negative overflow gives 1000..0.
  - co and ovf are reported unchanged.
  - Saturation logic sits in the final stage; latency is unchanged.
- Not defined: s is always the raw modular result; no saturation logic is present.

Test Plan:
- Reset: hold reset 2 cycles with valid_in=1 and stall=1 -> valid_out=0, s=0, co=0, ovf=0; nothing emerges in the next 10 cycles.
- Carry ripple (WIDTH=32, STAGES=4): add a=FFFFFFFF, b=00000001, ci=0 -> exactly 5 edges later valid_out=1, s=00000000, co=1, ovf=0; valid_out=0 before and after.
- Signed overflow: add a=7FFFFFFF, b=00000001, ci=0 -> s=80000000, co=0, ovf=1; with RCA_PIPE_SAT_EN -> s=7FFFFFFF, co=0, ovf=1.
- Subtract: sub=1, a=00000005, b=00000007, ci=1 -> s=FFFFFFFE, co=0, ovf=0. Also sub=1, a=80000000, b=00000001 -> s=7FFFFFFF, co=1, ovf=1; with RCA_PIPE_SAT_EN -> s=80000000.
- Streaming + stall: issue 8 back-to-back adds a=i, b=i*16 (i=0..7) and assert stall 3 cycles after the 3rd issue -> outputs freeze during stall; results s=i*17 appear in order, each exactly once, no gaps other than the 3 stalled cycles.
- Reset mid-stream: after 3 of 8 issues, pulse reset 1 cycle -> valid_out=0 from the next cycle; no pre-reset result ever appears. An op issued after reset returns correctly at STAGES+1 latency; repeat with STAGES=1 and STAGES=32.
